// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war game blocks.
package tow_pkg;

   // LFSR output width, shared by every consumer of the random stream
   localparam int TOW_RAND_W = 10;

   typedef enum logic [1:0] {CP_IDLE, CP_HOLD, CP_COOLDOWN} cp_state_e;

   // Down-counter width able to hold max(hold, cooldown); never narrower than 1 bit
   function automatic int cp_timer_w(input int hold_c, input int cool_c);
      int m;
      int w;
      m = (hold_c > cool_c) ? hold_c : cool_c;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/computer_player.sv
// Computer opponent: on a decision tick, presses the key when the LFSR value
// falls below the difficulty threshold, holds it, then cools down.
module computer_player
   import tow_pkg::*;
#(
   parameter int WIDTH           = TOW_RAND_W,
   parameter int HOLD_CYCLES     = 4,
   parameter int COOLDOWN_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] rand_val,
   input  logic [WIDTH-1:0] difficulty,
   input  logic             enable,
   input  logic             tick,
   output logic             press,
   output logic             busy,
   output logic [CNT_W-1:0] press_count
);

   localparam int TW = cp_timer_w(HOLD_CYCLES, COOLDOWN_CYCLES);
   localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
   // Unused when there is no cooldown; clamp so the load value never goes negative
   localparam logic [TW-1:0] COOL_LD = (COOLDOWN_CYCLES == 0) ? '0 : TW'(COOLDOWN_CYCLES - 1);

   cp_state_e        state, state_n;
   logic [TW-1:0]    timer, timer_n;
   logic             press_n, busy_n;
   logic [CNT_W-1:0] cnt_n;
   logic             hit;

   assign hit = enable & tick & (rand_val < difficulty);

   // Next-state, timer and output decode; ticks outside IDLE are simply dropped
   always_comb begin
      state_n = state;
      timer_n = timer;
      press_n = press;
      busy_n  = busy;
      cnt_n   = press_count;
      case (state)
         CP_IDLE: begin
            if (hit) begin
               state_n = CP_HOLD;
               timer_n = HOLD_LD;
               press_n = 1'b1;
               busy_n  = 1'b1;
               if (press_count != {CNT_W{1'b1}})
                  cnt_n = press_count + CNT_W'(1);
            end
         end
         CP_HOLD: begin
            if (!enable) begin
               state_n = CP_IDLE;
               timer_n = '0;
               press_n = 1'b0;
               busy_n  = 1'b0;
            end else if (timer == '0) begin
               press_n = 1'b0;
               if (COOLDOWN_CYCLES == 0) begin
                  state_n = CP_IDLE;
                  busy_n  = 1'b0;
               end else begin
                  state_n = CP_COOLDOWN;
                  timer_n = COOL_LD;
               end
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         CP_COOLDOWN: begin
            press_n = 1'b0;
            if (!enable || timer == '0) begin
               state_n = CP_IDLE;
               timer_n = '0;
               busy_n  = 1'b0;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         default: begin
            state_n = CP_IDLE;
            timer_n = '0;
            press_n = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
   end

   // State, timer and all outputs registered together; reset wins over everything
   always_ff @(posedge clk) begin
      if (Reset) begin
         state       <= CP_IDLE;
         timer       <= '0;
         press       <= 1'b0;
         busy        <= 1'b0;
         press_count <= '0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         press       <= press_n;
         busy        <= busy_n;
         press_count <= cnt_n;
      end
   end

endmodule

// File: tb/tb_computer_player.sv
// Bench for computer_player: three parameterizations share one input stream and
// are checked every cycle against a cycle-index based reference model.
module tb_computer_player;

   logic       clk = 1'b0;
   logic       Reset;
   logic [9:0] rand_val, difficulty;
   logic       enable, tick;

   logic [2:0] pr, bz;
   logic [7:0] pc0, pc2;
   logic [1:0] pc1;

   always #5 clk = ~clk;

   // 0: defaults, 1: 2-bit counter, 2: no cooldown
   computer_player #(.WIDTH(10), .HOLD_CYCLES(4), .COOLDOWN_CYCLES(16), .CNT_W(8)) dut0 (
      .clk(clk), .Reset(Reset), .rand_val(rand_val), .difficulty(difficulty),
      .enable(enable), .tick(tick), .press(pr[0]), .busy(bz[0]), .press_count(pc0));
   computer_player #(.WIDTH(10), .HOLD_CYCLES(4), .COOLDOWN_CYCLES(16), .CNT_W(2)) dut1 (
      .clk(clk), .Reset(Reset), .rand_val(rand_val), .difficulty(difficulty),
      .enable(enable), .tick(tick), .press(pr[1]), .busy(bz[1]), .press_count(pc1));
   computer_player #(.WIDTH(10), .HOLD_CYCLES(4), .COOLDOWN_CYCLES(0), .CNT_W(8)) dut2 (
      .clk(clk), .Reset(Reset), .rand_val(rand_val), .difficulty(difficulty),
      .enable(enable), .tick(tick), .press(pr[2]), .busy(bz[2]), .press_count(pc2));

   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a press is described by its rise cycle; the player is busy
   // for H+C cycles starting at the rise and presses for the first H of them.
   int  H[3]    = '{4, 4, 4};
   int  C[3]    = '{16, 16, 0};
   int  MAXC[3] = '{255, 3, 255};
   longint cyc = 0;
   longint m_rise[3];
   bit  m_act[3];
   int  m_cnt[3];
   bit  e_press[3], e_busy[3];
   int  e_cnt[3];

   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (Reset) begin
            m_act[d] = 1'b0;
            m_cnt[d] = 0;
         end else if (m_act[d] && cyc < m_rise[d] + H[d] + C[d]) begin
            if (!enable) m_act[d] = 1'b0;
         end else if (enable && tick && (rand_val < difficulty)) begin
            m_act[d]  = 1'b1;
            m_rise[d] = cyc + 1;
            if (m_cnt[d] < MAXC[d]) m_cnt[d]++;
         end
         e_press[d] = m_act[d] && (cyc + 1 >= m_rise[d]) && (cyc + 1 < m_rise[d] + H[d]);
         e_busy[d]  = m_act[d] && (cyc + 1 < m_rise[d] + H[d] + C[d]);
         e_cnt[d]   = m_cnt[d];
      end
      cyc++;
   end

   bit cmp_en = 1'b0;

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("press[%0d]", d), int'(pr[d]), int'(e_press[d]));
            chk($sformatf("busy[%0d]", d), int'(bz[d]), int'(e_busy[d]));
         end
         chk("count[0]", int'(pc0), e_cnt[0]);
         chk("count[1]", int'(pc1), e_cnt[1]);
         chk("count[2]", int'(pc2), e_cnt[2]);
      end
   end

   // Measurement of press shape for the literal checks
   int samp = 0;
   int ph0, bh0;
   int last_rise[3], gap[3];
   bit prev_pr[3];

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         samp++;
         for (int d = 0; d < 3; d++) begin
            if (pr[d] && !prev_pr[d]) begin
               gap[d] = samp - last_rise[d];
               last_rise[d] = samp;
            end
            prev_pr[d] = pr[d];
         end
         if (pr[0]) ph0++;
         if (bz[0]) bh0++;
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick  = 1'b0;
      run_cycles(2);
      Reset = 1'b0;
   endtask

   int exp_sat[5] = '{1, 2, 3, 3, 3};

   initial begin
      // Reset held with an otherwise certain hit pending
      Reset = 1'b1; tick = 1'b1; enable = 1'b1; difficulty = 10'd1023; rand_val = 10'd0;
      @(negedge clk);
      cmp_en = 1'b1;
      run_cycles(1);
      chk("rst_press", int'(pr[0]), 0);
      chk("rst_busy", int'(bz[0]), 0);
      chk("rst_count", int'(pc0), 0);

      // Single hit: 4 press cycles, 20 busy cycles
      do_reset();
      difficulty = 10'd512; rand_val = 10'd100;
      ph0 = 0; bh0 = 0;
      tick = 1'b1;
      run_cycles(1);
      tick = 1'b0;
      run_cycles(24);
      chk("single_press_len", ph0, 4);
      chk("single_busy_len", bh0, 20);
      chk("single_count", int'(pc0), 1);

      // No hit when rand_val >= difficulty or difficulty == 0
      do_reset();
      ph0 = 0;
      difficulty = 10'd512; rand_val = 10'd600; tick = 1'b1;
      run_cycles(50);
      difficulty = 10'd0; rand_val = 10'd0;
      run_cycles(50);
      tick = 1'b0;
      chk("nohit_press", ph0, 0);
      chk("nohit_count", int'(pc0), 0);

      // Continuous tick: rise spacing H+C+1, or H+1 without cooldown
      do_reset();
      difficulty = 10'd1023; rand_val = 10'd0;
      for (int d = 0; d < 3; d++) begin last_rise[d] = 0; gap[d] = 0; end
      tick = 1'b1;
      run_cycles(90);
      tick = 1'b0;
      chk("period_cool16", gap[0], 21);
      chk("period_cool0", gap[2], 5);

      // Saturating 2-bit counter over separated hits
      do_reset();
      for (int k = 0; k < 5; k++) begin
         tick = 1'b1;
         run_cycles(1);
         tick = 1'b0;
         run_cycles(24);
         chk($sformatf("sat_count%0d", k), int'(pc1), exp_sat[k]);
      end

      // enable dropped in 2nd HOLD cycle
      do_reset();
      tick = 1'b1;
      run_cycles(1);
      tick = 1'b0;
      run_cycles(1);
      enable = 1'b0;
      run_cycles(1);
      chk("abort_press", int'(pr[0]), 0);
      chk("abort_busy", int'(bz[0]), 0);
      chk("abort_count", int'(pc0), 1);
      enable = 1'b1;
      run_cycles(3);

      // Reset in 2nd HOLD cycle clears the counter
      tick = 1'b1;
      run_cycles(1);
      tick = 1'b0;
      run_cycles(1);
      Reset = 1'b1;
      run_cycles(1);
      Reset = 1'b0;
      chk("rst_hold_press", int'(pr[0]), 0);
      chk("rst_hold_count", int'(pc0), 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rand_val = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 49) == 0) difficulty = 10'($urandom_range(0, 1023));
         tick   = ($urandom_range(0, 2) == 0);
         enable = ($urandom_range(0, 39) != 0);
         Reset  = ($urandom_range(0, 299) == 0);
         run_cycles(1);
      end
      Reset = 1'b0;
      run_cycles(2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
